packet_buffer: RTL and testbench
================================

PACKET_BUFFER -- requirements
Module: packet_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, buffer capacity in bytes; must be a power of two, minimum 8.
REQ-002 SHALL have parameter BYTES, default 4, lane count of each data port; must be between 1 and 8, and no greater than DEPTH.
REQ-003 SHALL have derived widths CW = $clog2(BYTES+1) and OW = $clog2(DEPTH)+1.
REQ-004 SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-005 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1 bit: synchronous empty request.
REQ-007 SHALL have port clear, input, 1 bit: synchronous empty request, identical in effect to flush.
REQ-008 SHALL have port wr_cnt, input, CW bits: number of bytes to store this cycle, 0 to BYTES.
REQ-009 SHALL have port wr_data, input, 8*BYTES bits: write data; lane 0 (bits 7:0) is stored first.
REQ-010 SHALL have port rd_cnt, input, CW bits: number of bytes to consume this cycle, 0 to BYTES.
REQ-011 SHALL have port rd_data, output, 8*BYTES bits: oldest unread bytes; lane 0 is the oldest.
REQ-012 SHALL have port occupancy, output, OW bits: unread byte count.
REQ-013 SHALL have port full, output, 1 bit: asserted when free space is 0.
REQ-014 SHALL have port empty, output, 1 bit: asserted when occupancy is 0.
REQ-015 SHALL have port overflow, output, 1 bit: sticky, set when a write is rejected.
REQ-016 SHALL have port underflow, output, 1 bit: sticky, set when a read is rejected.

Function
REQ-017 SHALL store bytes in a circular array using write pointer wp, read pointer rp and mark pointer mp, each OW bits wide and compared modulo 2*DEPTH.
REQ-018 SHALL compute occupancy = wp - rp and free = DEPTH - (wp - mp); with PACKET_BUFFER_ROLLBACK_EN undefined, mp SHALL always equal rp.
REQ-019 SHALL accept a write only when wr_cnt <= free: lanes 0..wr_cnt-1 are written to addresses wp..wp+wr_cnt-1 (mod DEPTH) and wp advances by wr_cnt.
REQ-020 SHALL reject a write when wr_cnt > free: no byte is written, wp is unchanged and overflow is set; there are no partial writes.
REQ-021 SHALL accept a read only when rd_cnt <= occupancy, advancing rp by rd_cnt; otherwise rp is unchanged and underflow is set.
REQ-022 SHALL treat wr_cnt > BYTES and rd_cnt > BYTES as rejected, setting overflow or underflow respectively.
REQ-023 SHALL evaluate a simultaneous read and write against pre-edge state: a byte written in cycle N is not readable until cycle N+1, and space freed by a read in cycle N is not writable until cycle N+1.
REQ-024 SHALL drive rd_data combinationally from rp with zero latency; lanes at index >= occupancy read as 8'h00.
REQ-025 SHALL wrap pointers across the array end with no gap or bubble, so a 4-byte access spanning address DEPTH-1 to address 0 is contiguous.
REQ-026 SHALL derive full, empty and occupancy combinationally from registered pointers.
REQ-027 SHALL give flush or clear priority over all other inputs: wp, rp and mp go to 0, overflow and underflow clear, and the same-cycle read and write are ignored.
REQ-028 SHALL NOT clear array contents on flush or clear; stale bytes are masked per REQ-024.

Reset
REQ-029 SHALL on n_rst low immediately set wp, rp and mp to 0, clearing overflow and underflow.
REQ-030 SHALL present in reset: occupancy 0, empty 1, full 0, rd_data all zero.
REQ-031 SHALL abort any in-flight operation when reset is asserted mid-operation; no write or read completes on the edge where n_rst is low.

Configuration
REQ-032 SHALL support macro PACKET_BUFFER_ROLLBACK_EN, which adds input ports mark (1 bit) and rollback (1 bit).
REQ-033 SHALL with PACKET_BUFFER_ROLLBACK_EN defined, on mark: mp <= rp + accepted rd_cnt of the same cycle.
REQ-034 SHALL with PACKET_BUFFER_ROLLBACK_EN defined, on rollback: rp <= mp; a same-cycle read is ignored with no underflow, rollback wins over mark, and a same-cycle write proceeds normally.
REQ-035 SHALL with PACKET_BUFFER_ROLLBACK_EN defined, hold bytes between mp and rp against overwrite, so they count against free.
REQ-036 SHALL with PACKET_BUFFER_ROLLBACK_EN undefined, omit the mark and rollback ports, and SHALL treat consumed bytes as immediately free.

Verification (DEPTH=64, BYTES=4)
REQ-037 SHALL cover: reset, write 4 bytes 0x44332211, then read 2 -> rd_data=0x00004433, occupancy=2.
REQ-038 SHALL cover: fill to 62, write wr_cnt=3 -> overflow=1, occupancy stays 62; then write 2 -> full=1, occupancy=64.
REQ-039 SHALL cover: with occupancy=1, rd_cnt=2 -> underflow=1, rp unchanged; then flush -> underflow=0, empty=1.
REQ-040 SHALL cover: wp=rp=62, write 4 bytes 0xDDCCBBAA -> rd_data=0xDDCCBBAA read across the wrap point.
REQ-041 SHALL cover: occupancy=4, simultaneous wr_cnt=4 and rd_cnt=4 -> occupancy=4 next cycle, and rd_data shows the new bytes.
REQ-042 SHALL cover, with PACKET_BUFFER_ROLLBACK_EN defined: mark, read 8, rollback -> occupancy restored and the first 4 bytes reappear on rd_data.

Source files
------------

// File: rtl/packet_buffer.sv
// packet_buffer: byte-granular circular packet buffer with multi-lane write and read ports.
//
// Each cycle, up to BYTES bytes can be written and up to BYTES bytes consumed.
// rd_data always shows the oldest unread bytes, with zero latency.
// An access that does not fit is rejected as a whole and sets a sticky error flag.
//
// Parameters:
//   DEPTH - buffer capacity in bytes (power of two, >= 8)
//   BYTES - lanes per data port (1..8, <= DEPTH)
//
// Ports:
//   clk         - clock, rising edge
//   n_rst       - asynchronous active-low reset
//   flush/clear - synchronous empty request (identical effect, highest priority)
//   wr_cnt      - bytes to store this cycle (0..BYTES)
//   wr_data     - write lanes, lane 0 (bits 7:0) stored first
//   rd_cnt      - bytes to consume this cycle (0..BYTES)
//   rd_data     - oldest unread bytes, lane 0 oldest, lanes past occupancy read 0
//   occupancy   - unread byte count
//   full/empty  - no free space / no unread bytes
//   overflow    - sticky, a write was rejected
//   underflow   - sticky, a read was rejected
//
// Optional feature macro: PACKET_BUFFER_ROLLBACK_EN adds the mark and rollback inputs.
//   mark     - remember the read position (after this cycle's accepted read);
//              bytes behind the mark stay protected
//   rollback - rewind the read pointer to the mark
module packet_buffer #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned BYTES = 4
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           flush,
    input  logic                           clear,
`ifdef PACKET_BUFFER_ROLLBACK_EN
    input  logic                           mark,
    input  logic                           rollback,
`endif
    input  logic [$clog2(BYTES+1)-1:0]     wr_cnt,
    input  logic [8*BYTES-1:0]             wr_data,
    input  logic [$clog2(BYTES+1)-1:0]     rd_cnt,
    output logic [8*BYTES-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]         occupancy,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int unsigned CW = $clog2(BYTES + 1);
    localparam int unsigned OW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [OW-1:0] wp;
    logic [OW-1:0] rp;
    logic [OW-1:0] mp;
    logic [7:0]    mem [DEPTH];

    logic [OW-1:0] occ_c;
    logic [OW-1:0] free_c;
    logic          flush_c;
    logic          wr_ok_c;
    logic          rd_fit_c;
    logic          rd_en_c;
    logic          rd_ok_c;
    logic          rd_bad_c;
    logic [CW-1:0] rd_step_c;

    // Pointers carry one extra wrap bit, so the differences below are exact modulo 2*DEPTH.
    assign occ_c   = wp - rp;
    assign free_c  = OW'(DEPTH) - (wp - mp);
    assign flush_c = flush | clear;

    // Accept only whole accesses that fit the pre-edge state. Over-range counts never fit.
    assign wr_ok_c  = (32'(wr_cnt) <= BYTES) && (OW'(wr_cnt) <= free_c);
    assign rd_fit_c = (32'(rd_cnt) <= BYTES) && (OW'(rd_cnt) <= occ_c);

`ifdef PACKET_BUFFER_ROLLBACK_EN
    // A rollback overrides any read issued in the same cycle, without flagging underflow.
    assign rd_en_c = ~rollback;
`else
    assign rd_en_c = 1'b1;
`endif

    assign rd_ok_c   = rd_en_c & rd_fit_c;
    assign rd_bad_c  = rd_en_c & ~rd_fit_c;
    assign rd_step_c = rd_ok_c ? rd_cnt : CW'(0);

    // Write pointer, read pointer and sticky error flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wp        <= '0;
            rp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush_c) begin
            wp        <= '0;
            rp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wp <= wp + OW'(wr_cnt);
            end else begin
                overflow <= 1'b1;
            end
`ifdef PACKET_BUFFER_ROLLBACK_EN
            if (rollback) begin
                rp <= mp;
            end else begin
                rp <= rp + OW'(rd_step_c);
            end
`else
            rp <= rp + OW'(rd_step_c);
`endif
            if (rd_bad_c) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef PACKET_BUFFER_ROLLBACK_EN
    // Mark pointer. Rollback keeps the mark where it is.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mp <= '0;
        end else if (flush_c) begin
            mp <= '0;
        end else if (!rollback && mark) begin
            mp <= rp + OW'(rd_step_c);
        end
    end
`else
    // Without rollback, consumed bytes are free at once.
    assign mp = rp;
`endif

    // Byte storage. It is never cleared; bytes past occupancy are masked on read.
    always_ff @(posedge clk) begin
        if (n_rst && !flush_c && wr_ok_c) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (32'(wr_cnt) > i) begin
                    mem[AW'(wp + OW'(i))] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Zero-latency read window starting at rp, wrapping through address 0.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (OW'(i) < occ_c) begin
                rd_data[8*i +: 8] = mem[AW'(rp + OW'(i))];
            end
        end
    end

    assign occupancy = occ_c;
    assign full      = (free_c == '0);
    assign empty     = (occ_c == '0);

endmodule

// File: tb/tb_packet_buffer.sv
// tb_packet_buffer: self-checking bench for packet_buffer (DEPTH=64, BYTES=4, default build).
// The reference is a byte queue holding the unread bytes plus two sticky flags.
// Every output is compared against that queue on each falling edge.
// Hand-computed literal checks pin the reference on the directed cases.
module tb_packet_buffer;

    localparam int DEPTH = 64;
    localparam int BYTES = 4;

    logic        clk;
    logic        n_rst;
    logic        flush;
    logic        clear;
    logic [2:0]  wr_cnt;
    logic [31:0] wr_data;
    logic [2:0]  rd_cnt;
    logic [31:0] rd_data;
    logic [6:0]  occupancy;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;

    packet_buffer #(.DEPTH(DEPTH), .BYTES(BYTES)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .clear     (clear),
        .wr_cnt    (wr_cnt),
        .wr_data   (wr_data),
        .rd_cnt    (rd_cnt),
        .rd_data   (rd_data),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: the unread bytes (oldest first) and the sticky flags.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Asynchronous reset empties the reference at once.
    always @(negedge n_rst) begin
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    end

    // Reference update: each access is judged against the state before the edge.
    always @(posedge clk) begin
        int sz;
        int wc;
        int rc;
        sz = q.size();
        wc = int'(wr_cnt);
        rc = int'(rd_cnt);
        if (!n_rst || flush || clear) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (rc <= BYTES && rc <= sz) begin
                repeat (rc) void'(q.pop_front());
            end else begin
                m_unf = 1'b1;
            end
            if (wc <= BYTES && wc <= DEPTH - sz) begin
                for (int i = 0; i < wc; i++) q.push_back(wr_data[8*i +: 8]);
            end else begin
                m_ovf = 1'b1;
            end
        end
    end

    // Compare every output against the reference, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        exp_rd = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < q.size()) exp_rd[8*i +: 8] = q[i];
        end
        check("rd_data",   64'(rd_data),   64'(exp_rd));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("full",      64'(full),      64'(q.size() == DEPTH));
        check("empty",     64'(empty),     64'(q.size() == 0));
        check("overflow",  64'(overflow),  64'(m_ovf));
        check("underflow", 64'(underflow), 64'(m_unf));
    end

    // Drive one cycle of inputs starting at a falling edge, and return at the next falling edge.
    task automatic step(input logic f, input logic c, input int wc, input logic [31:0] wd, input int rc);
        flush   = f;
        clear   = c;
        wr_cnt  = 3'(wc);
        wr_data = wd;
        rd_cnt  = 3'(rc);
        @(posedge clk);
        @(negedge clk);
        flush  = 1'b0;
        clear  = 1'b0;
        wr_cnt = '0;
        rd_cnt = '0;
    endtask

    task automatic fill(input int n);
        int left;
        left = n;
        while (left > 0) begin
            step(0, 0, (left > 4) ? 4 : left, $urandom, 0);
            left -= 4;
        end
    endtask

    task automatic drain(input int n);
        int left;
        left = n;
        while (left > 0) begin
            step(0, 0, 0, 32'h0, (left > 4) ? 4 : left);
            left -= 4;
        end
    endtask

    // Assert reset mid-cycle while an access is pending, then release it away from the edge.
    task automatic mid_reset();
        wr_cnt  = 3'd4;
        wr_data = $urandom;
        rd_cnt  = 3'd1;
        #2 n_rst = 1'b0;
        #1;
        check("rst_async_occupancy", 64'(occupancy), 64'd0);
        check("rst_async_empty",     64'(empty),     64'd1);
        check("rst_async_rd_data",   64'(rd_data),   64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 n_rst = 1'b1;
        wr_cnt = '0;
        rd_cnt = '0;
        @(negedge clk);
    endtask

    initial begin
        n_rst   = 1'b0;
        flush   = 1'b0;
        clear   = 1'b0;
        wr_cnt  = '0;
        wr_data = '0;
        rd_cnt  = '0;
        repeat (2) @(negedge clk);
        check("reset_occupancy", 64'(occupancy), 64'd0);
        check("reset_empty",     64'(empty),     64'd1);
        check("reset_full",      64'(full),      64'd0);
        check("reset_rd_data",   64'(rd_data),   64'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Write 4 bytes, then read 2.
        step(0, 0, 4, 32'h4433_2211, 0);
        check("w4_rd_data", 64'(rd_data), 64'h4433_2211);
        step(0, 0, 0, 32'h0, 2);
        check("r2_rd_data",   64'(rd_data),   64'h0000_4433);
        check("r2_occupancy", 64'(occupancy), 64'd2);

        // Fill to 62, reject an oversized write, then fill to full.
        step(1, 0, 0, 32'h0, 0);
        fill(62);
        step(0, 0, 3, 32'h00AB_CDEF, 0);
        check("ovf_flag",      64'(overflow),  64'd1);
        check("ovf_occupancy", 64'(occupancy), 64'd62);
        step(0, 0, 2, 32'h0000_1234, 0);
        check("full_flag",      64'(full),      64'd1);
        check("full_occupancy", 64'(occupancy), 64'd64);
        // When full, a same-cycle read does not make room for a write.
        step(0, 0, 4, 32'h0, 4);
        check("full_rw_occupancy", 64'(occupancy), 64'd60);

        // Underflow holds the read pointer; flush clears the flag.
        step(0, 1, 0, 32'h0, 0);
        step(0, 0, 1, 32'h0000_005A, 0);
        step(0, 0, 0, 32'h0, 2);
        check("unf_flag",      64'(underflow), 64'd1);
        check("unf_occupancy", 64'(occupancy), 64'd1);
        check("unf_rd_data",   64'(rd_data),   64'h0000_005A);
        step(1, 0, 4, 32'h0, 1);
        check("flush_unf",   64'(underflow), 64'd0);
        check("flush_empty", 64'(empty),     64'd1);

        // Read and write across the array end at pointers 62.
        fill(62);
        drain(62);
        step(0, 0, 4, 32'hDDCC_BBAA, 0);
        check("wrap_rd_data", 64'(rd_data), 64'hDDCC_BBAA);

        // Simultaneous write and read: new bytes appear next cycle.
        step(0, 0, 4, 32'h8877_6655, 4);
        check("rw_occupancy", 64'(occupancy), 64'd4);
        check("rw_rd_data",   64'(rd_data),   64'h8877_6655);

        // Over-range counts are rejected even when they would fit.
        step(0, 0, 5, 32'hFFFF_FFFF, 0);
        check("wr5_ovf", 64'(overflow), 64'd1);
        step(0, 0, 0, 32'h0, 6);
        check("rd6_unf", 64'(underflow), 64'd1);

        mid_reset();

        // Randomized traffic: first biased toward filling, then toward draining.
        for (int n = 0; n < 1600; n++) begin
            int  wc;
            int  rc;
            logic f;
            logic c;
            wc = ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            rc = ($urandom_range(0, 19) == 0) ? int'($urandom_range(5, 7))
               : (n < 800) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
            if (n >= 800 && wc <= 4) wc = int'($urandom_range(0, 3));
            f = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 99) == 0);
            step(f, c, wc, $urandom, rc);
            if (n == 900) mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
